// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-read-port register file for the MIPS
// datapath, with a hardwired zero register, optional write-to-read bypass,
// a per-register pending-write scoreboard and a sequenced bulk-clear engine.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   we         write enable
//   waddr      write address
//   wdata      write data
//   raddr      NREAD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata      NREAD packed read data (combinational), same packing
//   busy       per-port scoreboard bit of the addressed register
//   rsv_valid  reserve the scoreboard bit of rsv_addr
//   rsv_addr   register to reserve
//   clr_req    start a bulk clear
//   clr_busy   high while the clear engine sweeps the array
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [NREAD*ADDR_W-1:0]   raddr,
  output logic [NREAD*DATA_W-1:0]   rdata,
  output logic [NREAD-1:0]          busy,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_addr,
  input  logic                      clr_req,
  output logic                      clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   ptr_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [DEPTH-1:0]    sb_r;

  logic [NREAD*DATA_W-1:0] rdata_s;
  logic [NREAD-1:0]        busy_s;
  logic [ADDR_W-1:0]       ra_s;
  logic                    hit_s;

  // Array, scoreboard and clear-engine state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= '0;
      sb_r    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          // A write also releases the reservation on its register.
          if (we && (waddr != '0)) begin
            mem_r[waddr] <= wdata;
            sb_r[waddr]  <= 1'b0;
          end
          if (clr_req) begin
            // Whole scoreboard cleared; a concurrent reservation is dropped,
            // a concurrent write lands and is swept later. Register 0 is
            // never written, so the sweep starts at 1.
            sb_r    <= '0;
            ptr_r   <= ADDR_W'(1);
            state_r <= ST_CLEAR;
          end else if (rsv_valid && (rsv_addr != '0)) begin
            // Issued after the release so a same-cycle new producer wins.
            sb_r[rsv_addr] <= 1'b1;
          end
        end
        ST_CLEAR: begin
          mem_r[ptr_r] <= '0;
          if (ptr_r == LAST_IDX) begin
            ptr_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            ptr_r <= ptr_r + ADDR_W'(1);
          end
        end
        default: begin
          ptr_r   <= '0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-port read data and busy, with bypass from the write port.
  always_comb begin
    rdata_s = '0;
    busy_s  = '0;
    ra_s    = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < NREAD; k++) begin
      ra_s  = raddr[k*ADDR_W +: ADDR_W];
      hit_s = (BYPASS != 0) && we && (waddr == ra_s);
      if (state_r == ST_CLEAR) begin
        rdata_s[k*DATA_W +: DATA_W] = '0;
        busy_s[k]                   = 1'b1;
      end else if (ra_s == '0) begin
        rdata_s[k*DATA_W +: DATA_W] = '0;
        busy_s[k]                   = 1'b0;
      end else begin
        if (hit_s) begin
          rdata_s[k*DATA_W +: DATA_W] = wdata;
        end else begin
          rdata_s[k*DATA_W +: DATA_W] = mem_r[ra_s];
        end
        // The bypassed write clears busy unless a new reservation
        // targets the same register in this cycle.
        if (hit_s && !(rsv_valid && (rsv_addr == ra_s))) begin
          busy_s[k] = 1'b0;
        end else begin
          busy_s[k] = sb_r[ra_s];
        end
      end
    end
  end

  assign rdata    = rdata_s;
  assign busy     = busy_s;
  assign clr_busy = (state_r == ST_CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default instance (32x32, 2 ports, bypass on)
  logic        we, rsv_valid, clr_req;
  logic [4:0]  waddr, rsv_addr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  busy;
  logic        clr_busy;

  // Bypass-off instance
  logic        n_we, n_rsv_valid;
  logic [4:0]  n_waddr, n_rsv_addr;
  logic [31:0] n_wdata;
  logic [9:0]  n_raddr;
  logic [63:0] n_rdata;
  logic [1:0]  n_busy;
  logic        n_clr_busy;
  logic        n_clr_req = 1'b0;

  // Sweep instance (16-bit, 8 registers, 4 ports)
  logic        s_we, s_clr_req;
  logic [2:0]  s_waddr;
  logic [15:0] s_wdata;
  logic [11:0] s_raddr;
  logic [63:0] s_rdata;
  logic [3:0]  s_busy;
  logic        s_clr_busy;
  logic        s_rsv_valid = 1'b0;
  logic [2:0]  s_rsv_addr = 3'd0;

  regfile_mp u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .busy(busy), .rsv_valid(rsv_valid),
    .rsv_addr(rsv_addr), .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .we(n_we), .waddr(n_waddr), .wdata(n_wdata),
    .raddr(n_raddr), .rdata(n_rdata), .busy(n_busy), .rsv_valid(n_rsv_valid),
    .rsv_addr(n_rsv_addr), .clr_req(n_clr_req), .clr_busy(n_clr_busy)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NREAD(4)) u_sw (
    .clk(clk), .rst(rst), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .raddr(s_raddr), .rdata(s_rdata), .busy(s_busy), .rsv_valid(s_rsv_valid),
    .rsv_addr(s_rsv_addr), .clr_req(s_clr_req), .clr_busy(s_clr_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rsv;
    logic [4:0]  rsv_addr;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [1:0]  exp_busy;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                              input logic r, input logic [4:0] rva,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] eb);
    vec_t v;
    v.we = w; v.waddr = wa; v.wdata = wd; v.rsv = r; v.rsv_addr = rva;
    v.ra0 = a0; v.ra1 = a1; v.exp0 = e0; v.exp1 = e1; v.exp_busy = eb;
    return v;
  endfunction

  task automatic idle();
    we = 1'b0; waddr = 5'd0; wdata = 32'd0;
    rsv_valid = 1'b0; rsv_addr = 5'd0; clr_req = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [15:0] sexp [8];

    idle();
    raddr = 10'd0;
    n_we = 1'b0; n_waddr = 5'd0; n_wdata = 32'd0; n_raddr = 10'd0;
    n_rsv_valid = 1'b0; n_rsv_addr = 5'd0;
    s_we = 1'b0; s_waddr = 3'd0; s_wdata = 16'd0; s_raddr = 12'd0; s_clr_req = 1'b0;

    //          we    waddr  wdata          rsv   raddr  ra0    ra1    exp0           exp1           busy
    vecs[0]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'h0,        2'b00);
    vecs[1]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00);
    vecs[2]  = mk(1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00);
    vecs[3]  = mk(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b00);
    vecs[4]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd7, 32'h0,        32'hA5A5A5A5, 2'b00);
    vecs[5]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd0, 32'h0,        32'h0,        2'b01);
    vecs[6]  = mk(1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd9, 5'd9, 32'h99,       32'h99,       2'b00);
    vecs[7]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd5, 32'h99,       32'hDEADBEEF, 2'b00);
    vecs[8]  = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd9, 32'h99,       32'h99,       2'b00);
    vecs[9]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h99,       32'h99,       2'b11);
    vecs[10] = mk(1'b1, 5'd9, 32'h777,      1'b1, 5'd9, 5'd9, 5'd7, 32'h777,      32'hA5A5A5A5, 2'b01);
    vecs[11] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h777,      32'h777,      2'b11);
    vecs[12] = mk(1'b1, 5'd0, 32'h55,       1'b1, 5'd0, 5'd0, 5'd9, 32'h0,        32'h777,      2'b10);
    vecs[13] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00);
    vecs[14] = mk(1'b1, 5'd9, 32'h888,      1'b1, 5'd5, 5'd9, 5'd5, 32'h888,      32'hDEADBEEF, 2'b00);
    vecs[15] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd5, 32'h888,      32'hDEADBEEF, 2'b10);

    // Reset state
    raddr = {5'd5, 5'd3};
    #1;
    check("reset_rdata", rdata, 64'h0);
    check("reset_busy", {62'd0, busy}, 64'h0);
    check("reset_clr_busy", {63'd0, clr_busy}, 64'h0);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven vectors: outputs checked combinationally before the edge
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      rsv_valid = vecs[i].rsv; rsv_addr = vecs[i].rsv_addr;
      raddr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("vec%0d_rdata0", i), {32'd0, rdata[31:0]}, {32'd0, vecs[i].exp0});
      check($sformatf("vec%0d_rdata1", i), {32'd0, rdata[63:32]}, {32'd0, vecs[i].exp1});
      check($sformatf("vec%0d_busy", i), {62'd0, busy}, {62'd0, vecs[i].exp_busy});
    end
    @(negedge clk);
    idle();

    // Bypass disabled: same-cycle read returns the old value
    n_we = 1'b1; n_waddr = 5'd7; n_wdata = 32'hA5A5A5A5; n_raddr = {5'd0, 5'd7};
    #1;
    check("nb_same_cycle", {32'd0, n_rdata[31:0]}, 64'h0);
    @(negedge clk);
    n_we = 1'b0; n_rsv_valid = 1'b1; n_rsv_addr = 5'd7;
    #1;
    check("nb_next_cycle", {32'd0, n_rdata[31:0]}, 64'hA5A5A5A5);
    @(negedge clk);
    n_rsv_valid = 1'b0; n_we = 1'b1; n_wdata = 32'h11;
    #1;
    check("nb_wr_rdata", {32'd0, n_rdata[31:0]}, 64'hA5A5A5A5);
    check("nb_wr_busy", {63'd0, n_busy[0]}, 64'h1);
    @(negedge clk);
    n_we = 1'b0;
    #1;
    check("nb_after_rdata", {32'd0, n_rdata[31:0]}, 64'h11);
    check("nb_after_busy", {63'd0, n_busy[0]}, 64'h0);

    // Fill r1..r31 with their index, reserving odd registers
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we = 1'b1; waddr = 5'(i); wdata = 32'(i);
      rsv_valid = i[0]; rsv_addr = 5'(i);
    end
    @(negedge clk);
    idle();
    raddr = {5'd13, 5'd12};
    #1;
    check("fill_r12", {32'd0, rdata[31:0]}, 64'd12);
    check("fill_r13", {32'd0, rdata[63:32]}, 64'd13);
    check("fill_busy", {62'd0, busy}, 64'h2);

    // Bulk clear with a concurrent write to r2
    @(negedge clk);
    clr_req = 1'b1; we = 1'b1; waddr = 5'd2; wdata = 32'hFFFF;
    raddr = {5'd0, 5'd31};
    #1;
    check("clr_accept_busy", {63'd0, clr_busy}, 64'h0);
    cnt = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      clr_req = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'h3333;
      rsv_valid = 1'b1; rsv_addr = 5'd3;
      #1;
      if (t == 0) begin
        check("clr_rdata_forced", rdata, 64'h0);
        check("clr_busy_forced", {62'd0, busy}, 64'h3);
      end
      if (!clr_busy) break;
      cnt++;
    end
    check("clr_cycles", 64'(cnt), 64'd31);
    // First IDLE cycle: this write lands at the next edge
    rsv_valid = 1'b0; waddr = 5'd6; wdata = 32'h6666;
    @(negedge clk);
    idle();
    for (int i = 0; i < 32; i++) begin
      raddr = {5'(i), 5'(i)};
      #1;
      check($sformatf("post_clr_r%0d", i), {32'd0, rdata[31:0]}, (i == 6) ? 64'h6666 : 64'h0);
      check($sformatf("post_clr_busy%0d", i), {62'd0, busy}, 64'h0);
      @(negedge clk);
    end

    // Reset in the middle of a clear
    we = 1'b1; waddr = 5'd20; wdata = 32'hAA;
    @(negedge clk);
    idle();
    clr_req = 1'b1;
    raddr = {5'd20, 5'd20};
    cnt = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      clr_req = 1'b0;
      #1;
      if (clr_busy) cnt++;
      if (cnt == 10) break;
    end
    check("midclr_reach", 64'(cnt), 64'd10);
    rst = 1'b0;
    #1;
    check("midclr_clr_busy", {63'd0, clr_busy}, 64'h0);
    check("midclr_rdata", rdata, 64'h0);
    check("midclr_busy", {62'd0, busy}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    we = 1'b1; waddr = 5'd4; wdata = 32'h4444;
    @(negedge clk);
    idle();
    raddr = {5'd20, 5'd4};
    #1;
    check("post_rst_r4", {32'd0, rdata[31:0]}, 64'h4444);
    check("post_rst_r20", {32'd0, rdata[63:32]}, 64'h0);

    // Parameter sweep instance: four simultaneous reads
    sexp[0] = 16'h0000; sexp[1] = 16'h1111; sexp[2] = 16'h2222; sexp[3] = 16'h3333;
    sexp[4] = 16'h4444; sexp[5] = 16'h5555; sexp[6] = 16'h6666; sexp[7] = 16'h7777;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      s_we = 1'b1; s_waddr = 3'(i); s_wdata = sexp[i];
    end
    @(negedge clk);
    s_we = 1'b0;
    s_raddr = {3'd7, 3'd5, 3'd2, 3'd0};
    #1;
    check("sw_read_a", s_rdata, {sexp[7], sexp[5], sexp[2], sexp[0]});
    s_raddr = {3'd6, 3'd4, 3'd3, 3'd1};
    #1;
    check("sw_read_b", s_rdata, {sexp[6], sexp[4], sexp[3], sexp[1]});
    @(negedge clk);
    s_clr_req = 1'b1;
    cnt = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      s_clr_req = 1'b0;
      #1;
      if (!s_clr_busy) break;
      cnt++;
    end
    check("sw_clr_cycles", 64'(cnt), 64'd7);
    @(negedge clk);
    s_raddr = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    check("sw_post_clr_a", s_rdata, 64'h0);
    s_raddr = {3'd0, 3'd7, 3'd6, 3'd5};
    #1;
    check("sw_post_clr_b", s_rdata, 64'h0);
    check("sw_post_clr_busy", {60'd0, s_busy}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
